// File: rtl/ula_arbiter.sv
// Round-robin arbiter sharing one combinational ULA between two requesters.
// Registers operands/opcode into the ULA, captures its result and returns it tagged with the owner id.
module ula_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [7:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [7:0]       req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_flag,
    output logic             rsp_err,
    output logic [WIDTH-1:0] ula_a,
    output logic [WIDTH-1:0] ula_b,
    output logic [7:0]       ula_opcode,
    input  logic [WIDTH-1:0] ula_out,
    input  logic             ula_flag,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [7:0] OP_IDLE = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t           state;
    logic             last_grant;
    logic             gnt_id;
    logic             accept;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [7:0]       sel_op;

    function automatic logic is_legal(input logic [7:0] op);
        logic ok;
        ok = (op[7:4] == 4'h3);
        case (op)
            8'h20, 8'h21, 8'h23, 8'h24, 8'h25, 8'h26, 8'h28, 8'h29: ok = 1'b1;
            default: ;
        endcase
        return ok;
    endfunction

    // Combinational grant: contention goes to the requester that did not win last.
    always_comb begin
        gnt_id     = req1_valid;
        if (req0_valid && req1_valid) begin
            gnt_id = ~last_grant;
        end
        req0_ready = (state == IDLE) && req0_valid && !gnt_id;
        req1_ready = (state == IDLE) && req1_valid && gnt_id;
        accept     = req0_ready || req1_ready;
        sel_a      = gnt_id ? req1_a  : req0_a;
        sel_b      = gnt_id ? req1_b  : req0_b;
        sel_op     = gnt_id ? req1_op : req0_op;
    end

    // Opcode returns to OP_IDLE outside ISSUE so every issue presents an opcode edge to the ULA.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            ula_a      <= '0;
            ula_b      <= '0;
            ula_opcode <= OP_IDLE;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            rsp_flag   <= 1'b0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
            op_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        last_grant <= gnt_id;
                        rsp_id     <= gnt_id;
                        busy       <= 1'b1;
                        if (is_legal(sel_op)) begin
                            ula_a      <= sel_a;
                            ula_b      <= sel_b;
                            ula_opcode <= sel_op;
                            state      <= ISSUE;
                        end else begin
                            rsp_data  <= '0;
                            rsp_flag  <= 1'b0;
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end
                    end
                end
                ISSUE: begin
                    rsp_data   <= ula_out;
                    rsp_flag   <= ula_flag;
                    rsp_err    <= 1'b0;
                    rsp_valid  <= 1'b1;
                    ula_opcode <= OP_IDLE;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        op_count  <= op_count + CNT_W'(1);
                        state     <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    rsp_valid  <= 1'b0;
                    busy       <= 1'b0;
                    ula_opcode <= OP_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ula_arbiter.sv
// Scoreboard bench for ula_arbiter: behavioural ULA, queued requesters, and a
// transaction-level reference for arbitration, latency and results.
module tb_ula_arbiter;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [7:0]       req0_op, req1_op;
    logic             rsp_valid, rsp_ready, rsp_id, rsp_flag, rsp_err;
    logic [WIDTH-1:0] rsp_data, ula_a, ula_b;
    logic [7:0]       ula_opcode;
    logic [WIDTH-1:0] ula_out = '0;
    logic             ula_flag = 1'b0;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    ula_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_flag(rsp_flag), .rsp_err(rsp_err),
        .ula_a(ula_a), .ula_b(ula_b), .ula_opcode(ula_opcode),
        .ula_out(ula_out), .ula_flag(ula_flag),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } req_t;

    typedef struct {
        logic             id;
        logic             legal;
        logic [7:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] data;
        logic             flag;
        logic             err;
        int               lat;
    } exp_t;

    req_t q0[$];
    req_t q1[$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   rr_mode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic legal_op(input logic [7:0] op);
        return (op >= 8'h30 && op <= 8'h3F) ||
               (op inside {8'h20, 8'h21, 8'h23, 8'h24, 8'h25, 8'h26, 8'h28, 8'h29});
    endfunction

    function automatic logic [WIDTH-1:0] ula_res(input logic [7:0] op, input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [3:0] sh;
        sh = op[3:0];
        case (op)
            8'h20, 8'h21: return a + b;
            8'h23:        return a + WIDTH'(1);
            8'h24:        return a - WIDTH'(1);
            8'h25, 8'h26: return a - b;
            8'h28:        return a & b;
            8'h29:        return a | b;
            default:      return (op >= 8'h30 && op <= 8'h3F) ? (a ^ (b << sh)) : '0;
        endcase
    endfunction

    // Behavioural ULA: only re-evaluates when its opcode changes.
    logic [7:0] seen_op = 8'h00;
    initial forever begin
        @(posedge clk);
        #1;
        if (ula_opcode !== seen_op) begin
            ula_out  = ula_res(ula_opcode, ula_a, ula_b);
            ula_flag = ula_out[WIDTH-1];
            seen_op  = ula_opcode;
        end
    end

    // Requester 0: holds the queue head until accepted.
    initial begin
        logic took;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = 8'h00;
        forever begin
            @(negedge clk);
            took = req0_valid && req0_ready && rst_n;
            @(posedge clk);
            #1;
            if (took) void'(q0.pop_front());
            req0_valid = (q0.size() > 0);
            if (q0.size() > 0) begin
                req0_op = q0[0].op; req0_a = q0[0].a; req0_b = q0[0].b;
            end
        end
    end

    // Requester 1.
    initial begin
        logic took;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = 8'h00;
        forever begin
            @(negedge clk);
            took = req1_valid && req1_ready && rst_n;
            @(posedge clk);
            #1;
            if (took) void'(q1.pop_front());
            req1_valid = (q1.size() > 0);
            if (q1.size() > 0) begin
                req1_op = q1[0].op; req1_a = q1[0].a; req1_b = q1[0].b;
            end
        end
    end

    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rr_mode == 1) rsp_ready = 1'($urandom_range(0, 1));
            else              rsp_ready = (rr_mode == 0);
        end
    end

    // Monitor: transaction-level reference of one-outstanding-op arbitration.
    initial begin
        logic             m_busy = 1'b0;
        logic             m_last = 1'b1;
        int               age = 0;
        logic [CNT_W-1:0] m_cnt = '0;
        logic             exp_rv, exp_r0, exp_r1;
        exp_t             e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("reset_busy", busy, 0);
                check("reset_rsp_valid", rsp_valid, 0);
                check("reset_op_count", op_count, 0);
                check("reset_ula_opcode", ula_opcode, 0);
                check("reset_rsp_data", rsp_data, 0);
                m_busy = 1'b0; m_last = 1'b1; age = 0; m_cnt = '0;
                sb.delete();
                continue;
            end
            if (m_busy) age++;
            exp_rv = m_busy && (sb.size() > 0) && (age >= sb[0].lat);
            exp_r0 = !m_busy && req0_valid && (!req1_valid || m_last == 1'b1);
            exp_r1 = !m_busy && req1_valid && (!req0_valid || m_last == 1'b0);
            check("req0_ready", req0_ready, exp_r0);
            check("req1_ready", req1_ready, exp_r1);
            check("busy", busy, m_busy);
            check("rsp_valid", rsp_valid, exp_rv);
            check("op_count", op_count, m_cnt);
            if (exp_rv) begin
                check("rsp_id", rsp_id, sb[0].id);
                check("rsp_data", rsp_data, sb[0].data);
                check("rsp_flag", rsp_flag, sb[0].flag);
                check("rsp_err", rsp_err, sb[0].err);
            end
            if (m_busy && sb.size() > 0 && age == 1 && sb[0].legal) begin
                check("ula_opcode_issue", ula_opcode, sb[0].op);
                check("ula_a", ula_a, sb[0].a);
                check("ula_b", ula_b, sb[0].b);
            end else begin
                check("ula_opcode_idle", ula_opcode, 0);
            end
            if (exp_rv && rsp_ready) begin
                void'(sb.pop_front());
                m_cnt++;
                m_busy = 1'b0;
            end else if (exp_r0 || exp_r1) begin
                e.id    = exp_r1;
                e.op    = exp_r1 ? req1_op : req0_op;
                e.a     = exp_r1 ? req1_a : req0_a;
                e.b     = exp_r1 ? req1_b : req0_b;
                e.legal = legal_op(e.op);
                e.data  = e.legal ? ula_res(e.op, e.a, e.b) : '0;
                e.flag  = e.legal ? e.data[WIDTH-1] : 1'b0;
                e.err   = !e.legal;
                e.lat   = e.legal ? 2 : 1;
                sb.push_back(e);
                m_busy = 1'b1;
                age    = 0;
                m_last = e.id;
            end
        end
    end

    task automatic drain(input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk);
            #2;
            if (q0.size() == 0 && q1.size() == 0 && !busy && sb.size() == 0) done = 1'b1;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL drain_timeout: got pending=%0d want 0", q0.size() + q1.size() + sb.size());
        end
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic req_t rand_req();
        req_t r;
        logic [7:0] lst [8];
        lst = '{8'h20, 8'h21, 8'h23, 8'h24, 8'h25, 8'h26, 8'h28, 8'h29};
        case ($urandom_range(0, 3))
            0:       r.op = 8'($urandom);
            1:       r.op = 8'h30 + 8'($urandom_range(0, 15));
            default: r.op = lst[$urandom_range(0, 7)];
        endcase
        r.a = WIDTH'($urandom);
        r.b = WIDTH'($urandom);
        return r;
    endfunction

    initial begin
        logic hit;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        q0.push_back('{8'h20, 32'd5, 32'd7});
        drain(50);

        apply_reset();
        for (int i = 0; i < 4; i++) begin
            q0.push_back('{8'h25, 32'd10, 32'd3});
            q1.push_back('{8'h23, 32'd41, 32'd0});
        end
        drain(200);

        q0.push_back('{8'h20, 32'd1, 32'd1});
        q0.push_back('{8'h20, 32'd2, 32'd3});
        drain(50);

        q1.push_back('{8'h22, 32'd9, 32'd9});
        drain(50);

        // Consumer stalls for several cycles while a result is pending.
        rr_mode = 2;
        q0.push_back('{8'h21, 32'd100, 32'd23});
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(posedge clk);
            #2;
            hit = rsp_valid;
        end
        check("stall_rsp_seen", hit, 1);
        repeat (5) @(posedge clk);
        rr_mode = 0;
        drain(50);

        // Reset while the ULA is mid-issue.
        q0.push_back('{8'h20, 32'd3, 32'd4});
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(posedge clk);
            #2;
            hit = busy;
        end
        check("issue_reached", hit, 1);
        rst_n = 1'b0;
        #1;
        check("async_busy", busy, 0);
        check("async_ula_opcode", ula_opcode, 0);
        check("async_rsp_valid", rsp_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        q0.push_back('{8'h24, 32'd8, 32'd0});
        q1.push_back('{8'h29, 32'd8, 32'd1});
        drain(100);

        rr_mode = 1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) q0.push_back(rand_req());
            if ($urandom_range(0, 1) == 1) q1.push_back(rand_req());
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        drain(3000);
        rr_mode = 0;
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
